// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared field widths, ALU function codes and the packed
//             instruction layout used by the issue controller and its FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

   localparam int REG_W  = 4;
   localparam int FUNC_W = 4;
   localparam int ADDR_W = 8;
   localparam int INSN_W = FUNC_W + 3 * REG_W + ADDR_W;

   typedef enum logic [FUNC_W-1:0] {
      FN_ADD = 4'd0,
      FN_SUB = 4'd1,
      FN_MUL = 4'd2,
      FN_AND = 4'd3,
      FN_OR  = 4'd4,
      FN_XOR = 4'd5,
      FN_NOT = 4'd6,
      FN_SHL = 4'd7,
      FN_SHR = 4'd8,
      FN_INC = 4'd9,
      FN_DEC = 4'd10,
      FN_SLA = 4'd11
   } func_e;

   // Field order matches the upstream bus: {func, rd, rs1, rs2, addr}.
   typedef struct packed {
      logic [FUNC_W-1:0] func;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  rs1;
      logic [REG_W-1:0]  rs2;
      logic [ADDR_W-1:0] addr;
   } insn_t;

   // True when the instruction reads register r on either source port.
   function automatic logic reads_reg(input insn_t insn, input logic [REG_W-1:0] r);
      return (insn.rs1 == r) || (insn.rs2 == r);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_issue_fifo
//  Purpose  : DEPTH-entry instruction FIFO with push/pop, full/empty flags and
//             a synchronous clear. No bypass: a pushed entry becomes visible
//             at the head on the following cycle.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_issue_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int           AW      = $clog2(DEPTH);
   localparam logic [AW:0]  PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] slot_mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign rdata   = slot_mem[rptr_q[AW-1:0]];

   // Next-pointer computation; clear discards every queued entry.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (clear) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PTR_ONE;
         if (do_pop)  rptr_d = rptr_q + PTR_ONE;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (do_push) slot_mem[wptr_q[AW-1:0]] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_issue_ctrl
//  Purpose  : In-order issue scheduler for the 4-stage register/memory
//             pipeline. Queues instructions, issues at most one per cycle and
//             inserts bubbles while a source register's producer is still in
//             flight (no forwarding). Counts hazard bubbles.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_issue_ctrl
   import pipe_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int RD_LAT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_func,
   input  logic [3:0] in_rd,
   input  logic [3:0] in_rs1,
   input  logic [3:0] in_rs2,
   input  logic [7:0] in_addr,
   input  logic       flush,
   output logic       iss_valid,
   output logic [3:0] iss_func,
   output logic [3:0] iss_rd,
   output logic [3:0] iss_rs1,
   output logic [3:0] iss_rs2,
   output logic [7:0] iss_addr,
   output logic       busy,
   output logic [15:0] stall_cnt
);

   // The issue register covers a producer's first cycle; the scoreboard
   // covers the remaining RD_LAT-2 cycles it can still be read too early.
   // With RD_LAT=2 the scoreboard is not needed and is held empty.
   localparam int SB_LEN  = (RD_LAT > 2) ? RD_LAT - 2 : 1;
   localparam bit SB_USED = (RD_LAT > 2);

   insn_t                        in_insn;
   insn_t                        head;
   logic                         fifo_full;
   logic                         fifo_empty;
   logic                         push;
   logic                         pop;
   logic                         hazard;
   logic                         stall_inc;

   logic                         iss_valid_q, iss_valid_d;
   insn_t                        iss_q, iss_d;
   logic [SB_LEN-1:0]            sb_vld_q, sb_vld_d;
   logic [SB_LEN-1:0][REG_W-1:0] sb_rd_q, sb_rd_d;
   logic [15:0]                  stall_cnt_q, stall_cnt_d;

   assign in_insn  = {in_func, in_rd, in_rs1, in_rs2, in_addr};
   assign in_ready = rst_n && !fifo_full && !flush;
   assign push     = in_valid && in_ready;

   pipe_issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSN_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (push),
      .wdata (in_insn),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // RAW check of the queue head against every producer still in flight.
   always_comb begin
      hazard = 1'b0;
      if (iss_valid_q && reads_reg(head, iss_q.rd)) hazard = 1'b1;
      for (int i = 0; i < SB_LEN; i++) begin
         if (sb_vld_q[i] && reads_reg(head, sb_rd_q[i])) hazard = 1'b1;
      end
   end

   // Issue decision: pop a clean head, or count a bubble against a blocked one.
   always_comb begin
      pop         = !flush && !fifo_empty && !hazard;
      stall_inc   = !flush && !fifo_empty && hazard;
      iss_valid_d = pop;
      iss_d       = pop ? head : '0;
      stall_cnt_d = stall_cnt_q;
      if (stall_inc && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // Scoreboard shift; keeps ageing through flush because issued ops still write back.
   always_comb begin
      sb_vld_d = '0;
      sb_rd_d  = '0;
      if (SB_USED) begin
         sb_vld_d[0] = iss_valid_q;
         sb_rd_d[0]  = iss_q.rd;
         for (int i = 1; i < SB_LEN; i++) begin
            sb_vld_d[i] = sb_vld_q[i-1];
            sb_rd_d[i]  = sb_rd_q[i-1];
         end
      end
   end

   // State registers for the issue stage, scoreboard and stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid_q <= 1'b0;
         iss_q       <= '0;
         sb_vld_q    <= '0;
         sb_rd_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_q       <= iss_d;
         sb_vld_q    <= sb_vld_d;
         sb_rd_q     <= sb_rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign iss_valid = iss_valid_q;
   assign iss_func  = iss_q.func;
   assign iss_rd    = iss_q.rd;
   assign iss_rs1   = iss_q.rs1;
   assign iss_rs2   = iss_q.rs2;
   assign iss_addr  = iss_q.addr;
   assign stall_cnt = stall_cnt_q;
   assign busy      = !fifo_empty || iss_valid_q || (|sb_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_issue_ctrl
//  Purpose  : Self-checking bench for pipe_issue_ctrl. A queue plus
//             per-register "last write" timestamps predict every output each
//             cycle; directed scenarios pin timing with literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_issue_ctrl;
   import pipe_pkg::*;

   localparam int DEPTH  = 4;
   localparam int RD_LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_func = '0;
   logic [3:0]  in_rd = '0;
   logic [3:0]  in_rs1 = '0;
   logic [3:0]  in_rs2 = '0;
   logic [7:0]  in_addr = '0;
   logic        flush = 1'b0;
   logic        iss_valid;
   logic [3:0]  iss_func, iss_rd, iss_rs1, iss_rs2;
   logic [7:0]  iss_addr;
   logic        busy;
   logic [15:0] stall_cnt;

   pipe_issue_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_addr(in_addr), .flush(flush), .iss_valid(iss_valid),
      .iss_func(iss_func), .iss_rd(iss_rd), .iss_rs1(iss_rs1),
      .iss_rs2(iss_rs2), .iss_addr(iss_addr), .busy(busy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   longint iss_cyc [16];
   int     n_iss = 0;
   int     last_waits = 0;

   // Reference model state: queued instructions, cycle in which each register
   // was last issued as a destination, and the last cycle anything issued.
   logic [23:0] mq [$];
   longint      last_wr [16];
   longint      last_iss;
   logic        m_valid;
   logic [23:0] m_fields;
   logic [15:0] m_stall;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: an instruction may issue in cycle t only if t - (last issue of
   // each source register) >= RD_LAT; FIFO order, one per cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         foreach (last_wr[r]) last_wr[r] = -1000;
         last_iss = -1000;
         m_valid  = 1'b0;
         m_fields = '0;
         m_stall  = '0;
      end else begin
         logic [23:0] h;
         bit          take;
         bit          ok;
         take     = in_valid && !flush && (mq.size() < DEPTH);
         m_valid  = 1'b0;
         m_fields = '0;
         if (flush) begin
            mq.delete();
         end else if (mq.size() > 0) begin
            h  = mq[0];
            ok = ((cyc + 1 - last_wr[h[15:12]]) >= RD_LAT) &&
                 ((cyc + 1 - last_wr[h[11:8]]) >= RD_LAT);
            if (ok) begin
               void'(mq.pop_front());
               m_valid  = 1'b1;
               m_fields = h;
               last_wr[h[19:16]] = cyc + 1;
               last_iss = cyc + 1;
            end else if (m_stall != 16'hFFFF) begin
               m_stall = m_stall + 16'd1;
            end
         end
         if (take) mq.push_back({in_func, in_rd, in_rs1, in_rs2, in_addr});
      end
   end

   // Per-cycle comparison against the model, plus issue-time logging.
   always @(negedge clk) begin
      if (rst_n) begin
         if (iss_valid === 1'b1) begin
            iss_cyc[iss_rd] = cyc;
            n_iss++;
         end
         chk("in_ready", in_ready, (mq.size() < DEPTH) && !flush);
         chk("iss_valid", iss_valid, m_valid);
         chk("iss_fields", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, m_fields);
         chk("stall_cnt", stall_cnt, m_stall);
         chk("busy", busy, (mq.size() > 0) || ((cyc - last_iss) < RD_LAT - 1));
      end
   end

   task automatic clear_log();
      foreach (iss_cyc[r]) iss_cyc[r] = -1;
      n_iss = 0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_log();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one instruction and hold it until accepted; acc is the first cycle
   // the entry sits in the FIFO.
   task automatic push(input logic [3:0] f, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, output longint acc);
      bit r;
      int waits;
      in_valid = 1'b1;
      in_func  = f;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_addr  = 8'($urandom);
      waits    = 0;
      r        = 1'b0;
      while (!r && waits <= 50) begin
         @(negedge clk);
         r = in_ready;
         @(posedge clk);
         #1;
         if (!r) waits++;
      end
      if (!r) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: got waits=%0d, expected accept", waits);
      end
      acc        = cyc;
      last_waits = waits;
   endtask

   initial begin
      longint a, t, a5, a6;

      // Reset values, checked while rst_n is held low.
      #1 rst_n = 1'b0;
      #1;
      chk("rst_iss_valid", iss_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_fields", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, 0);
      @(posedge clk);
      #1;
      do_reset();

      // Independent stream; only SLA r4=r2<<r3 waits on SUB r3.
      push(FN_ADD, 4'd1, 4'd3, 4'd5, a);
      push(FN_MUL, 4'd2, 4'd3, 4'd8, t);
      push(FN_SUB, 4'd3, 4'd10, 4'd0, t);
      push(FN_SLA, 4'd4, 4'd2, 4'd3, t);
      push(FN_SUB, 4'd5, 4'd14, 4'd5, t);
      push(FN_ADD, 4'd6, 4'd15, 4'd13, t);
      idle(8);
      chk("t1_stall", stall_cnt, 2);
      chk("t1_first_lat", iss_cyc[1] - a, 1);
      chk("t1_mul_b2b", iss_cyc[2] - iss_cyc[1], 1);
      chk("t1_sub_b2b", iss_cyc[3] - iss_cyc[2], 1);
      chk("t1_sla_gap", iss_cyc[4] - iss_cyc[3], 3);
      chk("t1_tail", iss_cyc[6] - iss_cyc[4], 2);

      // Back-to-back RAW on rs1.
      do_reset();
      push(FN_ADD, 4'd1, 4'd2, 4'd3, a);
      push(FN_SUB, 4'd9, 4'd1, 4'd4, t);
      idle(6);
      chk("t2_gap", iss_cyc[9] - iss_cyc[1], 3);
      chk("t2_stall", stall_cnt, 2);
      chk("t2_issues", n_iss, 2);

      // RAW on rs2 with one independent op between.
      do_reset();
      push(FN_MUL, 4'd7, 4'd1, 4'd2, t);
      push(FN_ADD, 4'd8, 4'd2, 4'd3, t);
      push(FN_SUB, 4'd10, 4'd4, 4'd7, t);
      idle(6);
      chk("t3_gap", iss_cyc[10] - iss_cyc[7], 3);
      chk("t3_mid", iss_cyc[8] - iss_cyc[7], 1);
      chk("t3_stall", stall_cnt, 1);

      // Dependency chain fills the FIFO; the next push is refused until a pop.
      do_reset();
      push(FN_ADD, 4'd1, 4'd0, 4'd0, t);
      push(FN_ADD, 4'd2, 4'd1, 4'd0, t);
      push(FN_ADD, 4'd3, 4'd2, 4'd0, t);
      push(FN_ADD, 4'd4, 4'd3, 4'd0, t);
      push(FN_ADD, 4'd5, 4'd4, 4'd0, t);
      push(FN_ADD, 4'd6, 4'd5, 4'd0, a5);
      push(FN_ADD, 4'd7, 4'd6, 4'd0, a6);
      chk("t4_full_wait", last_waits, 2);
      chk("t4_acc_gap", a6 - a5, 3);
      chk("t4_ready_after_pop", (a6 - 1) - iss_cyc[3], 0);
      idle(24);
      chk("t4_all_issued", n_iss, 7);

      // Flush with three queued and a hazard pending on the head.
      do_reset();
      push(FN_ADD, 4'd1, 4'd0, 4'd0, t);
      push(FN_ADD, 4'd2, 4'd1, 4'd0, t);
      push(FN_ADD, 4'd3, 4'd2, 4'd0, t);
      push(FN_ADD, 4'd4, 4'd0, 4'd0, t);
      push(FN_ADD, 4'd5, 4'd0, 4'd0, t);
      in_valid = 1'b1;
      in_rd    = 4'd14;
      in_rs1   = 4'd0;
      in_rs2   = 4'd0;
      flush    = 1'b1;
      @(negedge clk);
      chk("t5_ready_in_flush", in_ready, 0);
      @(posedge clk);
      #1;
      flush  = 1'b0;
      in_rd  = 4'd6;
      in_rs1 = 4'd2;
      @(negedge clk);
      chk("t5_valid_after_flush", iss_valid, 0);
      chk("t5_busy_after_flush", busy, 1);
      @(posedge clk);
      #1;
      idle(4);
      @(negedge clk);
      chk("t5_busy_drained", busy, 0);
      @(posedge clk);
      #1;
      chk("t5_consumer_gap", iss_cyc[6] - iss_cyc[2], 3);
      chk("t5_issues", n_iss, 3);
      chk("t5_stall", stall_cnt, 2);

      // Asynchronous reset in the middle of a stream.
      do_reset();
      push(FN_ADD, 4'd1, 4'd0, 4'd0, t);
      push(FN_ADD, 4'd2, 4'd1, 4'd0, t);
      push(FN_ADD, 4'd3, 4'd0, 4'd0, t);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_iss_valid", iss_valid, 0);
      chk("t6_fields", {iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, 0);
      chk("t6_busy", busy, 0);
      chk("t6_stall", stall_cnt, 0);
      chk("t6_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_log();
      push(FN_ADD, 4'd8, 4'd1, 4'd2, a);
      idle(3);
      chk("t6_post_reset_lat", iss_cyc[8] - a, 1);

      // Randomised traffic with a narrow register range to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         in_valid = ($urandom_range(3) != 0);
         in_func  = 4'($urandom_range(11));
         in_rd    = 4'($urandom_range(5));
         in_rs1   = 4'($urandom_range(5));
         in_rs2   = 4'($urandom_range(5));
         in_addr  = 8'($urandom);
         flush    = ($urandom_range(39) == 0);
         if ($urandom_range(599) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      flush = 1'b0;
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
